// File: rtl/row_window_pkg.sv
// row_window_pkg: shared FSM states and window row offsets for the line-buffer sequencer.
package row_window_pkg;
    typedef enum logic [1:0] {IDLE, FILL, STREAM, FLUSH} state_t;
    localparam int WIN_ROWS = 3;
    localparam int OFF_BOT  = 1;
    localparam int OFF_MID  = 2;
    localparam int OFF_TOP  = 3;
endpackage

// File: rtl/row_window_ctrl_if.sv
// row_window_ctrl_if: pixel-in, line-buffer write and window-read signals of row_window_ctrl.
// stall_cnt exists only when ROW_WINDOW_STALL_CNT_EN is defined.
interface row_window_ctrl_if #(
    parameter int ROW_BITS    = 2,
    parameter int COL_BITS    = 9,
    parameter int HEIGHT_BITS = 9
);
    logic                   frame_start;
    logic [HEIGHT_BITS-1:0] img_height;
    logic                   pix_valid;
    logic                   pix_ready;
    logic                   wr_en;
    logic [ROW_BITS-1:0]    wr_row;
    logic [COL_BITS-1:0]    col;
    logic                   win_valid;
    logic                   win_ready;
    logic [ROW_BITS-1:0]    rd_row_top;
    logic [ROW_BITS-1:0]    rd_row_mid;
    logic [ROW_BITS-1:0]    rd_row_bot;
    logic                   busy;
    logic                   frame_done;
`ifdef ROW_WINDOW_STALL_CNT_EN
    logic [15:0]            stall_cnt;
`endif
    modport master (
        output frame_start, img_height, pix_valid, win_ready,
        input  pix_ready, wr_en, wr_row, col, win_valid,
               rd_row_top, rd_row_mid, rd_row_bot, busy, frame_done
`ifdef ROW_WINDOW_STALL_CNT_EN
             , stall_cnt
`endif
    );
    modport slave (
        input  frame_start, img_height, pix_valid, win_ready,
        output pix_ready, wr_en, wr_row, col, win_valid,
               rd_row_top, rd_row_mid, rd_row_bot, busy, frame_done
`ifdef ROW_WINDOW_STALL_CNT_EN
             , stall_cnt
`endif
    );
endinterface

// File: rtl/row_ptr_mod.sv
// row_ptr_mod: modular add/subtract of a row index against the NUM_ROWS rollover value.
module row_ptr_mod #(
    parameter int NUM_ROWS = 4,
    parameter int ROW_BITS = 2
) (
    input  logic                sub,
    input  logic [ROW_BITS-1:0] a,
    input  logic [ROW_BITS-1:0] b,
    output logic [ROW_BITS-1:0] y
);
    localparam logic [ROW_BITS:0] N = (ROW_BITS+1)'(NUM_ROWS);
    logic [ROW_BITS:0] ax, bx, s;
    always_comb begin
        ax = {1'b0, a};
        bx = {1'b0, b};
        s  = ax + bx;
        y  = sub ? (a < b ? ROW_BITS'(ax + N - bx) : a - b)
                 : (s >= N ? ROW_BITS'(s - N) : s[ROW_BITS-1:0]);
    end
endmodule

// File: rtl/row_window_ctrl.sv
// row_window_ctrl: circular line-buffer write/read-row sequencer for a 3x3 window.
// Define ROW_WINDOW_STALL_CNT_EN to add the saturating downstream stall counter.
module row_window_ctrl
    import row_window_pkg::*;
#(
    parameter int NUM_ROWS    = 4,
    parameter int ROW_BITS    = 2,
    parameter int COL_BITS    = 9,
    parameter int IMG_WIDTH   = 320,
    parameter int HEIGHT_BITS = 9
) (
    input logic              clk,
    input logic              rst,
    row_window_ctrl_if.slave bus
);
    localparam logic [COL_BITS-1:0]    LAST_COL = COL_BITS'(IMG_WIDTH - 1);
    localparam logic [HEIGHT_BITS-1:0] WIN_H    = HEIGHT_BITS'(WIN_ROWS);
    localparam logic [ROW_BITS-1:0]    O_BOT    = ROW_BITS'(OFF_BOT);
    localparam logic [ROW_BITS-1:0]    O_MID    = ROW_BITS'(OFF_MID);
    localparam logic [ROW_BITS-1:0]    O_TOP    = ROW_BITS'(OFF_TOP);

    state_t                 state;
    logic [ROW_BITS-1:0]    wr_row, wr_nxt, top, mid, bot;
    logic [COL_BITS-1:0]    col;
    logic [HEIGHT_BITS-1:0] row_cnt, cnt_nxt, height;
    logic                   done_q, adv, row_end, start;

    row_ptr_mod #(.NUM_ROWS(NUM_ROWS), .ROW_BITS(ROW_BITS)) u_inc (.sub(1'b0), .a(wr_row), .b(O_BOT), .y(wr_nxt));
    row_ptr_mod #(.NUM_ROWS(NUM_ROWS), .ROW_BITS(ROW_BITS)) u_top (.sub(1'b1), .a(wr_row), .b(O_TOP), .y(top));
    row_ptr_mod #(.NUM_ROWS(NUM_ROWS), .ROW_BITS(ROW_BITS)) u_mid (.sub(1'b1), .a(wr_row), .b(O_MID), .y(mid));
    row_ptr_mod #(.NUM_ROWS(NUM_ROWS), .ROW_BITS(ROW_BITS)) u_bot (.sub(1'b1), .a(wr_row), .b(O_BOT), .y(bot));

    // In STREAM the pixel write and the window read move as one transfer.
    always_comb begin
        bus.pix_ready = state == FILL || (state == STREAM && bus.win_ready);
        bus.win_valid = (state == STREAM && bus.pix_valid) || state == FLUSH;
        bus.wr_en     = bus.pix_valid && bus.pix_ready;
        adv           = state == FLUSH ? bus.win_ready : bus.wr_en;
        row_end       = adv && col == LAST_COL;
        cnt_nxt       = row_cnt + 1'b1;
        start         = state == IDLE && bus.frame_start && bus.img_height >= WIN_H;
    end

    assign bus.wr_row     = wr_row;
    assign bus.col        = col;
    assign bus.busy       = state != IDLE;
    assign bus.frame_done = done_q;
    assign bus.rd_row_top = state != IDLE ? top : '0;
    assign bus.rd_row_mid = state != IDLE ? mid : '0;
    assign bus.rd_row_bot = state != IDLE ? bot : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            wr_row  <= '0;
            col     <= '0;
            row_cnt <= '0;
            height  <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (adv) col <= row_end ? '0 : col + 1'b1;
            if (row_end && state != FLUSH) begin
                wr_row  <= wr_nxt;
                row_cnt <= cnt_nxt;
            end
            case (state)
                IDLE: if (start) begin
                    height  <= bus.img_height;
                    wr_row  <= '0;
                    col     <= '0;
                    row_cnt <= '0;
                    state   <= FILL;
                end
                FILL:   if (row_end && cnt_nxt == WIN_H) state <= height > WIN_H ? STREAM : FLUSH;
                STREAM: if (row_end && cnt_nxt == height) state <= FLUSH;
                FLUSH: if (row_end) begin
                    state  <= IDLE;
                    done_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ROW_WINDOW_STALL_CNT_EN
    logic [15:0] stall_q;
    always_ff @(posedge clk) begin
        if (rst || start) stall_q <= '0;
        else if (bus.win_valid && !bus.win_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 1'b1;
    end
    assign bus.stall_cnt = stall_q;
`endif
endmodule
